// File: rtl/bcd_operand_loader.sv
// Operand entry front-end for the 2-digit BCD adder: debounced-by-sync key presses
// capture operand A, then operand B with carry-in, and hand them off with Valid/Ack.
module bcd_operand_loader #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] SW,
  input  logic       Cin,
  input  logic       Load_n,
  input  logic       Ack,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic       CinQ,
  output logic       Valid,
  output logic       Err,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_RDY = 2'b10,
    S_ERR = 2'b11
  } state_t;

  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v);
    return digit_ok(v[7:4]) && digit_ok(v[3:0]);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   synced;
  logic                   press;

  assign synced = sync_q[SYNC_STAGES-1];
  assign press  = ~synced & prev_q & armed_q;

  // prime_q marks when the reset preset has flushed out of the synchronizer, so
  // arming only ever sees a real high sample and a key held through reset is ignored.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q  <= '1;
      prime_q <= '0;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], Load_n};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= synced;
      armed_q <= armed_q | (synced & prime_q[SYNC_STAGES-1]);
    end
  end

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       sw_ok;

  assign sw_ok = bcd_ok(SW);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    unique case (state_q)
      S_A, S_RDY: begin
        // In S_RDY a press outranks a simultaneous Ack and restarts entry of A.
        if (press) begin
          if (sw_ok) begin
            a_d     = SW;
            state_d = S_B;
          end else begin
            state_d = S_ERR;
          end
        end else if (state_q == S_RDY && Ack) begin
          state_d = S_A;
        end
      end
      S_B: begin
        if (press) begin
          if (sw_ok) begin
            b_d     = SW;
            cin_d   = Cin;
            state_d = S_RDY;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ERR: begin
        if (press) state_d = S_A;
      end
      default: state_d = S_A;
    endcase
    valid_d = (state_d == S_RDY);
    err_d   = (state_d == S_ERR);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_A;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign CinQ  = cin_q;
  assign Valid = valid_q;
  assign Err   = err_q;
  assign State = state_q;

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Directed bench for bcd_operand_loader with hand-computed expectations.
module tb_bcd_operand_loader;

  logic       Clock;
  logic       Reset;
  logic [7:0] SW;
  logic       Cin;
  logic       Load_n;
  logic       Ack;
  logic [7:0] A;
  logic [7:0] B;
  logic       CinQ;
  logic       Valid;
  logic       Err;
  logic [1:0] State;

  int n_vec  = 0;
  int n_miss = 0;

  bcd_operand_loader #(.SYNC_STAGES(2)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .SW    (SW),
    .Cin   (Cin),
    .Load_n(Load_n),
    .Ack   (Ack),
    .A     (A),
    .B     (B),
    .CinQ  (CinQ),
    .Valid (Valid),
    .Err   (Err),
    .State (State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h, want %02h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic ec, input logic ev, input logic ee, input logic [1:0] es);
    check_val({tag, ".A"}, A, ea);
    check_val({tag, ".B"}, B, eb);
    check_val({tag, ".CinQ"}, {7'd0, CinQ}, {7'd0, ec});
    check_val({tag, ".Valid"}, {7'd0, Valid}, {7'd0, ev});
    check_val({tag, ".Err"}, {7'd0, Err}, {7'd0, ee});
    check_val({tag, ".State"}, {6'd0, State}, {6'd0, es});
  endtask

  // Press lands on the 3rd edge after Load_n is first sampled low; returns #1 after it.
  task automatic press_go(input logic [7:0] sw, input logic cin, input logic with_ack);
    @(negedge Clock);
    SW = sw; Cin = cin; Load_n = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Ack = with_ack;
    @(posedge Clock);
    #1;
  endtask

  task automatic release_key();
    @(negedge Clock);
    Ack = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Load_n = 1'b1;
    repeat (4) @(posedge Clock);
  endtask

  task automatic pulse_ack();
    @(negedge Clock);
    Ack = 1'b1;
    @(posedge Clock);
    #1;
    @(negedge Clock);
    Ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check_all("rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (6) @(posedge Clock);
  endtask

  initial begin
    Reset = 1'b1; SW = 8'h00; Cin = 1'b0; Load_n = 1'b1; Ack = 1'b0;
    repeat (3) @(posedge Clock);
    do_reset();
    check_all("idle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);

    // Latency: no capture after 2 edges, capture on the 3rd.
    @(negedge Clock);
    SW = 8'h47; Load_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check_val("lat.early.State", {6'd0, State}, 8'h00);
    check_val("lat.early.A", A, 8'h00);
    @(posedge Clock);
    #1;
    check_all("capA", 8'h47, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01);
    release_key();
    check_all("capA.hold", 8'h47, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01);

    press_go(8'h38, 1'b1, 1'b0);
    check_all("capB", 8'h47, 8'h38, 1'b1, 1'b1, 1'b0, 2'b10);
    release_key();
    check_val("rdy.hold.Valid", {7'd0, Valid}, 8'h01);
    pulse_ack();
    check_all("ack", 8'h47, 8'h38, 1'b1, 1'b0, 1'b0, 2'b00);
    pulse_ack();
    check_val("ackSA.State", {6'd0, State}, 8'h00);

    press_go(8'h5A, 1'b0, 1'b0);
    check_all("errA", 8'h47, 8'h38, 1'b1, 1'b0, 1'b1, 2'b11);
    release_key();
    pulse_ack();
    check_val("ackERR.State", {6'd0, State}, 8'h03);
    press_go(8'h12, 1'b0, 1'b0);
    check_all("errClr", 8'h47, 8'h38, 1'b1, 1'b0, 1'b0, 2'b00);
    release_key();

    press_go(8'h11, 1'b1, 1'b0);
    release_key();
    press_go(8'h22, 1'b0, 1'b0);
    check_all("capB2", 8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 2'b10);
    release_key();
    press_go(8'h09, 1'b1, 1'b1);
    check_all("pressAck", 8'h09, 8'h22, 1'b0, 1'b0, 1'b0, 2'b01);
    release_key();

    pulse_ack();
    check_val("ackSB.State", {6'd0, State}, 8'h01);
    press_go(8'hA0, 1'b1, 1'b0);
    check_all("errB", 8'h09, 8'h22, 1'b0, 1'b0, 1'b1, 2'b11);
    release_key();
    press_go(8'h00, 1'b0, 1'b0);
    release_key();

    // Key held low across reset release must not count as a press.
    @(negedge Clock);
    Load_n = 1'b0;
    do_reset();
    repeat (6) @(posedge Clock);
    #1;
    check_all("heldKey", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge Clock);
    Load_n = 1'b1;
    repeat (4) @(posedge Clock);
    press_go(8'h33, 1'b0, 1'b0);
    check_all("afterHeld", 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01);
    release_key();

    press_go(8'h44, 1'b1, 1'b0);
    release_key();
    press_go(8'h55, 1'b0, 1'b0);
    check_all("toSB", 8'h55, 8'h44, 1'b1, 1'b0, 1'b0, 2'b01);
    release_key();
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bcd_operand_loader.md
BCD_OPERAND_LOADER -- requirements
Module: bcd_operand_loader

Upstream stage of the 2-digit BCD adder: sequentially captures operand A, then operand B plus carry-in, from the switches on key presses, validates each digit, and presents the registered operands with a valid/ack handshake.

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on Load_n (legal values 2..4).
REQ-002 Clock  input  1  system clock; all state updates on the rising edge.
REQ-003 Reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 SW  input  8  operand entry; [7:4] tens digit, [3:0] units digit, both BCD; sampled directly, with no synchronizer.
REQ-005 Cin  input  1  carry-in, sampled together with operand B.
REQ-006 Load_n  input  1  raw push-button, active-low, asynchronous to Clock.
REQ-007 Ack  input  1  downstream consumed the operands; single-cycle pulse.
REQ-008 A  output  8  registered operand A (two BCD digits).
REQ-009 B  output  8  registered operand B (two BCD digits).
REQ-010 CinQ  output  1  registered carry-in.
REQ-011 Valid  output  1  A, B and CinQ form a complete operand set.
REQ-012 Err  output  1  the last press presented a non-BCD digit.
REQ-013 State  output  2  current FSM state, for LED display.

Function
REQ-014 Load_n SHALL pass through SYNC_STAGES flops; a press is defined as: synchronized level low, previous synchronized level high, and the armed flag set.
REQ-015 The armed flag SHALL be cleared by Reset and set the first cycle the synchronized level is high.
  - Consequence: a key held through reset release never yields a press.
REQ-016 Press latency: the press is acted on at the (SYNC_STAGES+1)th rising edge after Load_n is first sampled low.
  - At most one press per low pulse of Load_n.
REQ-017 A digit is invalid if it is greater than 9; SW is invalid if either digit is invalid.
REQ-018 FSM states: S_A=00, S_B=01, S_RDY=10, S_ERR=11; State SHALL equal the current encoding.
REQ-019 S_A, on a press:
  - SW valid: A<=SW, next state S_B.
  - SW invalid: A unchanged, Err<=1, next state S_ERR.
REQ-020 S_B, on a press:
  - SW valid: B<=SW, CinQ<=Cin, Valid<=1, next state S_RDY.
  - SW invalid: B and CinQ unchanged, Err<=1, next state S_ERR.
REQ-021 S_RDY: Valid SHALL hold at 1 until Ack or a press.
  - Ack alone: Valid<=0, next state S_A; A, B and CinQ are retained.
REQ-022 S_RDY, press (with or without Ack in the same cycle): the press wins.
  - Valid<=0, then handled exactly as a press in S_A (REQ-019).
REQ-023 S_ERR: the next press SHALL set Err<=0 and go to S_A, capturing nothing; Ack is ignored.
REQ-024 Ack in S_A, S_B or S_ERR SHALL have no effect.
REQ-025 Valid SHALL be 1 only in S_RDY; Err SHALL be 1 only in S_ERR.
REQ-026 A, B and CinQ SHALL change only on the capture edges of REQ-019 and REQ-020.

Reset
REQ-027 Reset SHALL set A=0x00, B=0x00, CinQ=0, Valid=0, Err=0, State=00, clear the armed flag, and set the synchronizer flops to 1.
  - This takes effect on the next rising edge, from any state, including mid-press.
REQ-028 Reset SHALL take priority over press and Ack in the same cycle.

Verification
REQ-029 After reset, SW=0x47, press Load_n -> SYNC_STAGES+1 edges later A=0x47, State=01, Valid=0.
REQ-030 Then SW=0x38, Cin=1, press -> B=0x38, CinQ=1, Valid=1, State=10; one-cycle Ack -> Valid=0, State=00, A=0x47 and B=0x38 retained.
REQ-031 In S_A, SW=0x5A, press -> Err=1, State=11, A unchanged.
  - Next press with SW=0x12 -> Err=0, State=00, A still unchanged.
REQ-032 In S_RDY, press with SW=0x09 together with Ack in the same cycle -> A=0x09, State=01, Valid=0.
REQ-033 Load_n held low across reset release -> no capture and State stays 00.
  - After release and a new press, capture occurs normally.
REQ-034 Reset asserted while in S_B -> next edge: all outputs return to their reset values; A=0x00.
